// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM stage with a multi-cycle word data memory feeding the MEM/WB register
//   in : clk, rst (async, active-low), memRead, memWrite, memtoReg, regWrite, aluResult, rs2Data, writeReg
//   out: stall (combinational), memtoReg_out, regWrite_out, readData_out, aluResult_out, writeReg_out, misaligned
module mem_wb_stage #(
  parameter int ADDR_W = 8,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic        memtoReg,
  input  logic        regWrite,
  input  logic [31:0] aluResult,
  input  logic [31:0] rs2Data,
  input  logic [4:0]  writeReg,
  output logic        stall,
  output logic        memtoReg_out,
  output logic        regWrite_out,
  output logic [31:0] readData_out,
  output logic [31:0] aluResult_out,
  output logic [4:0]  writeReg_out,
  output logic        misaligned
);
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [31:0] mem [2**ADDR_W];
  logic req, access, misal, done;
  logic [ADDR_W-1:0] idx;
  // stall and completion are gated by rst so nothing stalls or writes memory while held in reset
  always_comb begin
    req = memRead | memWrite;
    access = req && aluResult[1:0] == 2'b00;
    misal = req && aluResult[1:0] != 2'b00;
    idx = aluResult[ADDR_W+1:2];
    stall = rst && (state == BUSY ? cnt != CW'(LATENCY - 1) : access && LATENCY > 1);
    done = rst && !stall;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      memtoReg_out <= 1'b0;
      regWrite_out <= 1'b0;
      readData_out <= '0;
      aluResult_out <= '0;
      writeReg_out <= '0;
      misaligned <= 1'b0;
    end else if (stall) begin
      state <= BUSY;
      cnt <= state == IDLE ? CW'(1) : cnt + 1'b1;
      memtoReg_out <= 1'b0;
      regWrite_out <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      state <= IDLE;
      cnt <= '0;
      memtoReg_out <= memtoReg;
      regWrite_out <= regWrite & ~misal;
      readData_out <= access && memRead && !memWrite ? mem[idx] : '0;
      aluResult_out <= aluResult;
      writeReg_out <= writeReg;
      misaligned <= misal;
    end
  always_ff @(posedge clk)
    if (done && access && memWrite) mem[idx] <= rs2Data;
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: table, directed and random checks of mem_wb_stage at LATENCY 2 and 4
module tb_mem_wb_stage;
  typedef struct packed {
    logic memRead, memWrite, memtoReg, regWrite;
    logic [31:0] aluResult, rs2Data;
    logic [4:0] writeReg;
  } in_t;
  typedef struct {
    in_t in;
    logic expRw, expMtr, expMis;
    logic [31:0] expAlu;
    logic [4:0] expWr;
  } vec_t;
  logic clk = 1'b0, rst = 1'b0, sel = 1'b0;
  in_t cur = '0, in2, in4;
  logic stall2, mtr2, rw2, mis2, stall4, mtr4, rw4, mis4;
  logic [31:0] rd2, alu2, rd4, alu4;
  logic [4:0] wr2, wr4;
  logic stall, mtrO, rwO, misO;
  logic [31:0] rdO, aluO;
  logic [4:0] wrO;
  logic [31:0] mdl [2][256];
  int nChecks = 0, nFail = 0;
  vec_t tbl [6];
  always #5 clk = ~clk;
  // only the selected DUT sees live inputs; the other idles on zeros
  assign in2 = sel ? '0 : cur;
  assign in4 = sel ? cur : '0;
  assign {stall, mtrO, rwO, misO, rdO, aluO, wrO} = sel ? {stall4, mtr4, rw4, mis4, rd4, alu4, wr4}
                                                        : {stall2, mtr2, rw2, mis2, rd2, alu2, wr2};
  mem_wb_stage #(.ADDR_W(8), .LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .memRead(in2.memRead), .memWrite(in2.memWrite), .memtoReg(in2.memtoReg),
    .regWrite(in2.regWrite), .aluResult(in2.aluResult), .rs2Data(in2.rs2Data), .writeReg(in2.writeReg),
    .stall(stall2), .memtoReg_out(mtr2), .regWrite_out(rw2), .readData_out(rd2),
    .aluResult_out(alu2), .writeReg_out(wr2), .misaligned(mis2));
  mem_wb_stage #(.ADDR_W(8), .LATENCY(4)) dut4 (
    .clk(clk), .rst(rst), .memRead(in4.memRead), .memWrite(in4.memWrite), .memtoReg(in4.memtoReg),
    .regWrite(in4.regWrite), .aluResult(in4.aluResult), .rs2Data(in4.rs2Data), .writeReg(in4.writeReg),
    .stall(stall4), .memtoReg_out(mtr4), .regWrite_out(rw4), .readData_out(rd4),
    .aluResult_out(alu4), .writeReg_out(wr4), .misaligned(mis4));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic in_t mk(input logic rd, input logic wr, input logic mtr, input logic rw,
                             input logic [31:0] a, input logic [31:0] d, input logic [4:0] r);
    in_t x;
    x.memRead = rd;
    x.memWrite = wr;
    x.memtoReg = mtr;
    x.regWrite = rw;
    x.aluResult = a;
    x.rs2Data = d;
    x.writeReg = r;
    return x;
  endfunction
  function automatic in_t rnd();
    in_t x;
    int k;
    k = int'($urandom_range(4));
    x = mk(1'b0, 1'b0, 1'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom));
    if (k == 1) {x.memRead, x.memWrite} = 2'b10;
    if (k == 2) {x.memRead, x.memWrite} = 2'b01;
    if (k == 3) {x.memRead, x.memWrite} = 2'b11;
    if (k >= 1 && k <= 3) x.aluResult[1:0] = 2'b00;
    if (k == 4) begin
      {x.memRead, x.memWrite} = 2'($urandom_range(3, 1));
      x.aluResult[1:0] = 2'($urandom_range(3, 1));
    end
    return x;
  endfunction
  // One instruction end to end: stall length, bubbles, and the completed MEM/WB contents
  // derived from the transaction rules and a word-array memory model.
  task automatic run(input in_t x, input int lat);
    logic acc, mis;
    logic [7:0] idx;
    logic [31:0] expRd;
    int n;
    n = 0;
    cur = x;
    #1;
    acc = (x.memRead | x.memWrite) && x.aluResult[1:0] == 2'b00;
    mis = (x.memRead | x.memWrite) && !acc;
    idx = x.aluResult[9:2];
    expRd = acc && x.memRead && !x.memWrite ? mdl[sel][idx] : 32'h0;
    while (stall && n < 20) begin
      tick();
      n++;
      chk("bubble", 32'({rwO, mtrO, misO}), 32'h0);
    end
    chk("stallCycles", 32'(n), acc ? 32'(lat - 1) : 32'h0);
    tick();
    if (acc && x.memWrite) mdl[sel][idx] = x.rs2Data;
    chk("readData", rdO, expRd);
    chk("aluResult", aluO, x.aluResult);
    chk("writeReg", 32'(wrO), 32'(x.writeReg));
    chk("regWrite", 32'(rwO), 32'(x.regWrite & ~mis));
    chk("memtoReg", 32'(mtrO), 32'(x.memtoReg));
    chk("misaligned", 32'(misO), 32'(mis));
    cur = '0;
  endtask
  initial begin
    tbl[0] = '{mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h7, 32'h0, 5'd3), 1'b1, 1'b0, 1'b0, 32'h7, 5'd3};
    tbl[1] = '{mk(1'b1, 1'b0, 1'b1, 1'b1, 32'h13, 32'h0, 5'd9), 1'b0, 1'b1, 1'b1, 32'h13, 5'd9};
    tbl[2] = '{mk(1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFF0, 32'h1, 5'd31), 1'b0, 1'b1, 1'b0, 32'hFFFF_FFF0, 5'd31};
    tbl[3] = '{mk(1'b0, 1'b1, 1'b0, 1'b1, 32'h22, 32'h5555, 5'd1), 1'b0, 1'b0, 1'b1, 32'h22, 5'd1};
    tbl[4] = '{mk(1'b1, 1'b1, 1'b0, 1'b1, 32'h103, 32'h77, 5'd2), 1'b0, 1'b0, 1'b1, 32'h103, 5'd2};
    tbl[5] = '{mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0), 1'b0, 1'b0, 1'b0, 32'h0, 5'd0};
    cur = mk(1'b1, 1'b1, 1'b1, 1'b1, 32'h10, 32'hFFFF_FFFF, 5'd31);
    #2;
    chk("rstStall", 32'(stall), 32'h0);
    chk("rstOuts", 32'({rwO, mtrO, misO, wrO}), 32'h0);
    chk("rstRead", rdO, 32'h0);
    chk("rstAlu", aluO, 32'h0);
    sel = 1'b1;
    #1;
    chk("rstStall4", 32'(stall), 32'h0);
    sel = 1'b0;
    cur = '0;
    tick();
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      for (int i = 0; i < 256; i++) run(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'(i) << 2, $urandom, 5'd0), s == 0 ? 2 : 4);
    end
    sel = 1'b0;
    run(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'hDEAD_BEEF, 5'd0), 2);
    run(mk(1'b1, 1'b0, 1'b1, 1'b1, 32'h10, 32'h0, 5'd5), 2);
    chk("specLoadData", rdO, 32'hDEAD_BEEF);
    chk("specLoadReg", 32'(wrO), 32'd5);
    run(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h400, 32'h1234_5678, 5'd0), 2);
    run(mk(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 5'd6), 2);
    chk("wrapLoad", rdO, 32'h1234_5678);
    foreach (tbl[i]) begin
      cur = tbl[i].in;
      #1;
      chk("tblStall", 32'(stall), 32'h0);
      tick();
      chk("tblRegWrite", 32'(rwO), 32'(tbl[i].expRw));
      chk("tblMemtoReg", 32'(mtrO), 32'(tbl[i].expMtr));
      chk("tblMisaligned", 32'(misO), 32'(tbl[i].expMis));
      chk("tblAlu", aluO, tbl[i].expAlu);
      chk("tblWriteReg", 32'(wrO), 32'(tbl[i].expWr));
      chk("tblRead", rdO, 32'h0);
    end
    cur = '0;
    run(mk(1'b1, 1'b0, 1'b0, 1'b1, 32'h10, 32'h0, 5'd8), 2);
    chk("word4Intact", rdO, 32'hDEAD_BEEF);
    for (int i = 0; i < 300; i++) run(rnd(), 2);
    sel = 1'b1;
    run(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h1111_2222, 5'd0), 4);
    cur = mk(1'b0, 1'b1, 1'b1, 1'b1, 32'h20, 32'hAAAA_5555, 5'd7);
    #1;
    chk("midStall0", 32'(stall), 32'h1);
    tick();
    tick();
    chk("midStall2", 32'(stall), 32'h1);
    rst = 1'b0;
    #1;
    chk("midRstStall", 32'(stall), 32'h0);
    chk("midRstAlu", aluO, 32'h0);
    chk("midRstOuts", 32'({rwO, mtrO, misO, wrO}), 32'h0);
    cur = '0;
    tick();
    rst = 1'b1;
    run(mk(1'b1, 1'b0, 1'b1, 1'b1, 32'h20, 32'h0, 5'd4), 4);
    chk("midRstKeep", rdO, 32'h1111_2222);
    for (int i = 0; i < 150; i++) run(rnd(), 4);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
